// File: rtl/object_mover_pkg.sv
// Shared types and screen constants for the object_mover sprite position generator.
package object_mover_pkg;

  typedef enum logic {ACTIVE, RESPAWN} mover_state_t;
  typedef enum logic {BND_CLAMP, BND_WRAP} bnd_mode_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int POS_W    = 32;

endpackage

// File: rtl/object_mover_if.sv
// Control/status bundle between a frame/keyboard source and one object_mover instance.
interface object_mover_if;

  logic        startOfFrame;
  logic        hit;
  logic        right;
  logic        left;
  logic        up;
  logic        down;
  logic        wrapX;
  logic        wrapY;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        active;
  logic        edgeHit;

  modport master (
    output startOfFrame, hit, right, left, up, down, wrapX, wrapY,
    input  topLeftX, topLeftY, active, edgeHit
  );

  modport slave (
    input  startOfFrame, hit, right, left, up, down, wrapX, wrapY,
    output topLeftX, topLeftY, active, edgeHit
  );

endinterface

// File: rtl/object_mover_axis.sv
// One fixed-point axis (module mover_axis): velocity, position and limit handling.
// Define OBJECT_MOVER_ACCEL_EN for ramped velocity instead of instant speed.
module mover_axis
  import object_mover_pkg::*;
#(
  parameter int DATA_W    = POS_W,
  parameter int FRAC_BITS = 6,
  parameter int INIT      = 320,
  parameter int SPEED     = 128,
  parameter int MIN       = 0,
`ifdef OBJECT_MOVER_ACCEL_EN
  parameter int ACCEL     = 16,
`endif
  parameter int MAX       = 639
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        update_i,
  input  logic        load_i,
  input  logic        neg_i,
  input  logic        pos_i,
  input  bnd_mode_t   wrap_i,
  output logic [10:0] pos_out_o,
  output logic        edge_o
);

  localparam logic signed [DATA_W-1:0] INIT_S  = DATA_W'(INIT * (2 ** FRAC_BITS));
  localparam logic signed [DATA_W-1:0] SPD_S   = DATA_W'(SPEED);
  localparam logic signed [DATA_W-1:0] MIN_S   = DATA_W'(MIN * (2 ** FRAC_BITS));
  localparam logic signed [DATA_W-1:0] MAX_S   = DATA_W'(MAX * (2 ** FRAC_BITS));
  localparam logic signed [DATA_W-1:0] RANGE_S = DATA_W'((MAX - MIN + 1) * (2 ** FRAC_BITS));
`ifdef OBJECT_MOVER_ACCEL_EN
  localparam logic signed [DATA_W-1:0] ACC_S   = DATA_W'(ACCEL);
`endif

  logic signed [DATA_W-1:0] pos_q, pos_d;
  logic signed [DATA_W-1:0] vel_q, vel_d;
  logic signed [DATA_W-1:0] target;
  logic signed [DATA_W-1:0] sum;
  logic                     edge_q, edge_d;
`ifdef OBJECT_MOVER_ACCEL_EN
  logic signed [DATA_W-1:0] vel_step;

  function automatic logic signed [DATA_W-1:0] step_toward(
    input logic signed [DATA_W-1:0] v,
    input logic signed [DATA_W-1:0] t
  );
    if (t > v)      return ((t - v) > ACC_S) ? v + ACC_S : t;
    else if (t < v) return ((v - t) > ACC_S) ? v - ACC_S : t;
    else            return v;
  endfunction
`endif

  function automatic logic out_of_range(input logic signed [DATA_W-1:0] v);
    return (v > MAX_S) || (v < MIN_S);
  endfunction

  // Landing exactly on a limit stays put; only strict overshoot is clamped or wrapped.
  function automatic logic signed [DATA_W-1:0] apply_bounds(
    input logic signed [DATA_W-1:0] v,
    input bnd_mode_t                mode
  );
    if (v > MAX_S) return (mode == BND_WRAP) ? v - RANGE_S : MAX_S;
    if (v < MIN_S) return (mode == BND_WRAP) ? v + RANGE_S : MIN_S;
    return v;
  endfunction

  always_comb begin
    if (pos_i && !neg_i)      target = SPD_S;
    else if (neg_i && !pos_i) target = -SPD_S;
    else                      target = '0;
  end

  always_comb begin
`ifdef OBJECT_MOVER_ACCEL_EN
    vel_step = step_toward(vel_q, target);
    sum      = pos_q + vel_step;
    vel_d    = update_i ? vel_step : vel_q;
`else
    sum      = pos_q + vel_q;
    vel_d    = target;
`endif
    pos_d  = pos_q;
    edge_d = 1'b0;
    if (update_i) begin
      pos_d  = apply_bounds(sum, wrap_i);
      edge_d = out_of_range(sum);
`ifdef OBJECT_MOVER_ACCEL_EN
      if (out_of_range(sum) && (wrap_i == BND_CLAMP)) vel_d = '0;
`endif
    end
    if (load_i) begin
      pos_d  = INIT_S;
      vel_d  = '0;
      edge_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_q  <= INIT_S;
      vel_q  <= '0;
      edge_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      vel_q  <= vel_d;
      edge_q <= edge_d;
    end
  end

  assign pos_out_o = 11'(pos_q >>> FRAC_BITS);
  assign edge_o    = edge_q;

endmodule

// File: rtl/object_mover.sv
// Two-axis sprite mover with hit-triggered frozen respawn period.
// Optional macro OBJECT_MOVER_ACCEL_EN selects ramped velocity in both axes.
module object_mover
  import object_mover_pkg::*;
#(
  parameter int INITIAL_X      = 320,
  parameter int INITIAL_Y      = 450,
  parameter int X_SPEED        = 128,
  parameter int Y_SPEED        = 0,
  parameter int FRAC_BITS      = 6,
  parameter int MIN_X          = 0,
  parameter int MAX_X          = SCREEN_W - 1,
  parameter int MIN_Y          = 0,
  parameter int MAX_Y          = SCREEN_H - 1,
`ifdef OBJECT_MOVER_ACCEL_EN
  parameter int ACCEL          = 16,
`endif
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic          clk,
  input  logic          resetN,
  object_mover_if.slave bus
);

  localparam int CNT_W = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;

  mover_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;
  logic             is_active;
  logic             load;
  logic             update;
  logic             edge_x, edge_y;

  // Hit takes priority over a coincident frame update; keys are masked while respawning.
  assign is_active = (state_q == ACTIVE);
  assign load      = is_active && bus.hit;
  assign update    = is_active && bus.startOfFrame && !bus.hit;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ACTIVE;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (bus.hit) begin
            state_q  <= RESPAWN;
            cnt_q    <= CNT_W'(RESPAWN_FRAMES);
            active_q <= 1'b0;
          end
        end
        RESPAWN: begin
          if (cnt_q == '0) begin
            state_q  <= ACTIVE;
            active_q <= 1'b1;
          end else if (bus.startOfFrame) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q  <= ACTIVE;
          active_q <= 1'b1;
        end
      endcase
    end
  end

  mover_axis #(
    .FRAC_BITS (FRAC_BITS),
    .INIT      (INITIAL_X),
    .SPEED     (X_SPEED),
    .MIN       (MIN_X),
`ifdef OBJECT_MOVER_ACCEL_EN
    .ACCEL     (ACCEL),
`endif
    .MAX       (MAX_X)
  ) u_axis_x (
    .clk       (clk),
    .resetN    (resetN),
    .update_i  (update),
    .load_i    (load),
    .neg_i     (bus.left  && is_active),
    .pos_i     (bus.right && is_active),
    .wrap_i    (bnd_mode_t'(bus.wrapX)),
    .pos_out_o (bus.topLeftX),
    .edge_o    (edge_x)
  );

  mover_axis #(
    .FRAC_BITS (FRAC_BITS),
    .INIT      (INITIAL_Y),
    .SPEED     (Y_SPEED),
    .MIN       (MIN_Y),
`ifdef OBJECT_MOVER_ACCEL_EN
    .ACCEL     (ACCEL),
`endif
    .MAX       (MAX_Y)
  ) u_axis_y (
    .clk       (clk),
    .resetN    (resetN),
    .update_i  (update),
    .load_i    (load),
    .neg_i     (bus.up   && is_active),
    .pos_i     (bus.down && is_active),
    .wrap_i    (bnd_mode_t'(bus.wrapY)),
    .pos_out_o (bus.topLeftY),
    .edge_o    (edge_y)
  );

  assign bus.active  = active_q;
  assign bus.edgeHit = edge_x | edge_y;

endmodule

// File: tb/tb_object_mover.sv
// Self-checking bench for object_mover: frame vector tables plus respawn/reset sequences.
module tb_object_mover;

  logic clk = 1'b0;
  logic resetN = 1'b0;

  object_mover_if bus ();

  object_mover dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r, l, u, d, w;
    int ex_x;
    bit ex_edge;
  } vec_t;

  typedef struct {
    int x, y;
    bit edge_b, act;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(bit r, bit l, bit u, bit d, bit w, int x, bit e);
    vec_t v;
    v.r = r; v.l = l; v.u = u; v.d = d; v.w = w; v.ex_x = x; v.ex_edge = e;
    return v;
  endfunction

  task automatic expect_state(int x, int y, bit e, bit a);
    exp_t t;
    t.x = x; t.y = y; t.edge_b = e; t.act = a;
    exp_q.push_back(t);
  endtask

  task automatic cmp(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic check(string nm);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no expected entry, expected one queued", nm);
      return;
    end
    e = exp_q.pop_front();
    cmp({nm, ".x"},      int'(bus.topLeftX), e.x);
    cmp({nm, ".y"},      int'(bus.topLeftY), e.y);
    cmp({nm, ".edge"},   int'(bus.edgeHit),  int'(e.edge_b));
    cmp({nm, ".active"}, int'(bus.active),   int'(e.act));
  endtask

  // Keys settle for one clock, then one startOfFrame pulse; sampled 1ns after the update edge.
  task automatic do_frame(bit r, bit l, bit u, bit d, bit w, bit hit_b);
    bus.right = r; bus.left = l; bus.up = u; bus.down = d;
    bus.wrapX = w; bus.wrapY = w;
    @(posedge clk); #1;
    bus.startOfFrame = 1'b1;
    bus.hit          = hit_b;
    @(posedge clk); #1;
    bus.startOfFrame = 1'b0;
    bus.hit          = 1'b0;
  endtask

  task automatic run_table(string tag);
    foreach (vecs[i]) begin
      expect_state(vecs[i].ex_x, 450, vecs[i].ex_edge, 1'b1);
      do_frame(vecs[i].r, vecs[i].l, vecs[i].u, vecs[i].d, vecs[i].w, 1'b0);
      check($sformatf("%s[%0d]", tag, i));
    end
    vecs.delete();
  endtask

  initial begin
    bus.startOfFrame = 1'b0; bus.hit = 1'b0;
    bus.right = 1'b0; bus.left = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
    bus.wrapX = 1'b0; bus.wrapY = 1'b0;

    #12;
    expect_state(320, 450, 1'b0, 1'b1);
    check("reset");
    @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;

`ifdef OBJECT_MOVER_ACCEL_EN
    // Velocity ramps 16,32,..,128 units; position accumulates the fraction exactly.
    vecs.push_back(mk(1,0,0,0,0, 320, 0));
    vecs.push_back(mk(1,0,0,0,0, 320, 0));
    vecs.push_back(mk(1,0,0,0,0, 321, 0));
    vecs.push_back(mk(1,0,0,0,0, 322, 0));
    vecs.push_back(mk(1,0,0,0,0, 323, 0));
    vecs.push_back(mk(1,0,0,0,0, 325, 0));
    vecs.push_back(mk(1,0,0,0,0, 327, 0));
    vecs.push_back(mk(1,0,0,0,0, 329, 0));
    vecs.push_back(mk(1,0,0,0,0, 331, 0));
    run_table("accel");
`else
    for (int i = 1; i <= 10; i++) vecs.push_back(mk(1,0,i[0],0,0, 320 + 2*i, 0));
    run_table("right10");

    for (int i = 0; i < 145; i++) do_frame(1,0,0,0,0, 1'b0);
    expect_state(630, 450, 1'b0, 1'b1);
    check("at630");

    vecs.push_back(mk(1,0,0,0,0, 632, 0));
    vecs.push_back(mk(1,0,0,0,0, 634, 0));
    vecs.push_back(mk(1,0,0,1,0, 636, 0));
    vecs.push_back(mk(1,0,0,0,0, 638, 0));
    vecs.push_back(mk(1,0,0,0,0, 639, 1));
    vecs.push_back(mk(1,0,0,0,0, 639, 1));
    vecs.push_back(mk(0,0,0,0,0, 639, 0));
    vecs.push_back(mk(1,1,0,0,0, 639, 0));
    vecs.push_back(mk(0,1,0,0,0, 637, 0));
    vecs.push_back(mk(1,0,0,0,0, 639, 0));
    vecs.push_back(mk(1,0,0,0,1,   1, 1));
    vecs.push_back(mk(1,1,1,0,1,   1, 0));
    vecs.push_back(mk(1,1,0,0,0,   1, 0));
    vecs.push_back(mk(0,1,0,0,1, 639, 1));
    vecs.push_back(mk(1,0,0,0,1,   1, 1));
    vecs.push_back(mk(0,1,0,0,0,   0, 1));
    vecs.push_back(mk(0,1,0,0,0,   0, 1));
    vecs.push_back(mk(0,0,0,0,0,   0, 0));
    vecs.push_back(mk(1,0,0,0,0,   2, 0));
    vecs.push_back(mk(0,1,0,0,0,   0, 0));
    run_table("bounds");

    for (int i = 0; i < 200; i++) do_frame(1,0,0,0,0, 1'b0);
    expect_state(400, 450, 1'b0, 1'b1);
    check("at400");
`endif

    // Hit coincident with a frame update wins; 60 frames of frozen respawn follow.
    expect_state(320, 450, 1'b0, 1'b0);
    do_frame(1,0,0,0,0, 1'b1);
    check("hit");
    for (int k = 1; k <= 60; k++) begin
      expect_state(320, 450, 1'b0, 1'b0);
      do_frame(1,0,k[0],0,0, k == 30);
      check($sformatf("respawn%0d", k));
    end
    @(posedge clk); #1;
    expect_state(320, 450, 1'b0, 1'b1);
    check("respawn_done");
`ifdef OBJECT_MOVER_ACCEL_EN
    expect_state(320, 450, 1'b0, 1'b1);
`else
    expect_state(322, 450, 1'b0, 1'b1);
`endif
    do_frame(1,0,0,0,0, 1'b0);
    check("resume");

    // Asynchronous reset in the middle of a respawn period.
    expect_state(320, 450, 1'b0, 1'b0);
    do_frame(0,0,0,0,0, 1'b1);
    check("hit2");
    for (int i = 0; i < 3; i++) do_frame(1,0,0,0,0, 1'b0);
    @(posedge clk); #3;
    resetN = 1'b0;
    #1;
    expect_state(320, 450, 1'b0, 1'b1);
    check("reset_mid");
    #2;
    resetN = 1'b1;
    @(posedge clk); #1;
    expect_state(320, 450, 1'b0, 1'b1);
    check("after_reset");
`ifdef OBJECT_MOVER_ACCEL_EN
    expect_state(320, 450, 1'b0, 1'b1);
`else
    expect_state(322, 450, 1'b0, 1'b1);
`endif
    do_frame(1,0,0,0,0, 1'b0);
    check("move_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
